// File: rtl/combo_input_sync.sv
`default_nettype none
// ============================================================================
// Module      : combo_input_sync
// Description : Front end for a combination lock. Brings eight raw switch
//               inputs into the clock domain, debounces each one, detects a
//               submit press and hands the captured code attempt to the lock
//               FSM over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles before a switch change is
//                     accepted (default 50000 = 1 ms at 50 MHz)
// Ports
//   clk        in   1  system clock, rising edge active
//   rst_n      in   1  asynchronous active-low reset
//   sw_code    in   6  raw code switches (asynchronous)
//   sw_submit  in   1  raw submit switch (asynchronous)
//   sw_en      in   1  raw lock-enable switch (asynchronous)
//   code_ready in   1  downstream lock FSM accepts the code
//   code       out  6  captured code attempt
//   code_valid out  1  code holds an unconsumed attempt
//   en_level   out  1  debounced enable level
//   overrun    out  1  sticky: a submit was dropped while an attempt pended
// ============================================================================
module combo_input_sync #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sw_code,
  input  logic       sw_submit,
  input  logic       sw_en,
  input  logic       code_ready,
  output logic [5:0] code,
  output logic       code_valid,
  output logic       en_level,
  output logic       overrun
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int NUM_IN     = 8;
  localparam int IDX_SUBMIT = 6;
  localparam int IDX_EN     = 7;

  // Counter must be able to hold DEBOUNCE_CYCLES itself.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  // The stable value is updated on the edge where the counter would reach
  // DEBOUNCE_CYCLES, i.e. when it currently holds DEBOUNCE_CYCLES-1. This is
  // what makes a DEBOUNCE_CYCLES-long run of the new level sufficient and a
  // shorter run insufficient.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Input bundle: bits [5:0] code, [6] submit, [7] enable
  // --------------------------------------------------------------------------
  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] sync_meta;
  logic [NUM_IN-1:0] sync;
  logic [NUM_IN-1:0] stable;

  assign raw = {sw_en, sw_submit, sw_code};

  // --------------------------------------------------------------------------
  // Two-flop synchronizer for every raw input. Nothing downstream ever looks
  // at raw or sync_meta.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Per-input debouncer. The counter measures how long the synchronized
  // value has disagreed with the accepted (stable) value; any cycle of
  // agreement restarts the measurement, so a glitch shorter than
  // DEBOUNCE_CYCLES cycles can never be accepted.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_IN; i++) begin : g_debounce
      logic             stable_q;
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else if (sync[i] == stable_q) begin
          cnt_q    <= '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_q <= sync[i];
          cnt_q    <= '0;
        end else begin
          cnt_q    <= cnt_q + CNT_W'(1);
        end
      end

      assign stable[i] = stable_q;
    end
  endgenerate

  assign en_level = stable[IDX_EN];

  // --------------------------------------------------------------------------
  // Submit edge detection. Only a rising debounced submit counts, and only
  // while the lock is enabled; releasing the switch is not an event.
  // --------------------------------------------------------------------------
  logic submit_prev;
  logic submit_event;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      submit_prev <= 1'b0;
    end else begin
      submit_prev <= stable[IDX_SUBMIT];
    end
  end

  assign submit_event = stable[IDX_SUBMIT] & ~submit_prev & en_level;

  // --------------------------------------------------------------------------
  // Handshake FSM: IDLE has nothing to offer, HOLD presents code.
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   load_code;
  logic   set_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_code   = 1'b0;
    set_overrun = 1'b0;
    case (state)
      IDLE: begin
        // code_ready is deliberately ignored here: nothing is on offer.
        if (submit_event) begin
          state_nxt = HOLD;
          load_code = 1'b1;
        end
      end
      HOLD: begin
        if (!en_level) begin
          // Lock disabled while an attempt pends: abort and discard it.
          state_nxt = IDLE;
        end else if (code_ready) begin
          // The pending attempt is consumed this edge, so a simultaneous
          // new submit can take its place without loss.
          if (submit_event) begin
            load_code = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (submit_event) begin
          // Attempt still pending: keep it and flag the lost press.
          set_overrun = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Code capture and overrun flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= '0;
    end else if (load_code) begin
      code <= stable[5:0];
    end
  end

  // Disabling the lock clears the flag; it wins over a same-cycle set
  // (a set cannot actually coincide, as submit_event needs en_level=1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (!en_level) begin
      overrun <= 1'b0;
    end else if (set_overrun) begin
      overrun <= 1'b1;
    end
  end

  assign code_valid = (state == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_combo_input_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_combo_input_sync
// Description : Self-checking bench for combo_input_sync with
//               DEBOUNCE_CYCLES=4. Directed scenarios plus a random phase,
//               all compared each cycle against a behavioural model in which
//               an input is accepted once its last DEBOUNCE_CYCLES
//               synchronized samples all differ from the accepted value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_combo_input_sync;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] sw_code;
  logic       sw_submit;
  logic       sw_en;
  logic       code_ready;
  logic [5:0] code;
  logic       code_valid;
  logic       en_level;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;

  combo_input_sync #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_code   (sw_code),
    .sw_submit (sw_submit),
    .sw_en     (sw_en),
    .code_ready(code_ready),
    .code      (code),
    .code_valid(code_valid),
    .en_level  (en_level),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [7:0] hist[$];     // raw samples taken at past edges, newest last
  logic [7:0] m_stable;    // accepted levels {en, submit, code}
  logic       m_prev_sub;
  logic       m_valid;
  logic [5:0] m_code;
  logic       m_ovr;

  task automatic model_reset();
    m_stable   = '0;
    m_prev_sub = 1'b0;
    m_valid    = 1'b0;
    m_code     = '0;
    m_ovr      = 1'b0;
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(8'h00);
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    logic [7:0] raw_now;
    logic [7:0] nstable;
    logic       ev;
    logic       en;
    logic       all_diff;
    int         n;
    raw_now = {sw_en, sw_submit, sw_code};
    en      = m_stable[7];
    ev      = m_stable[6] && !m_prev_sub && en;

    if (!en) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else if (ev) begin
      if (!m_valid || code_ready) begin
        m_valid = 1'b1;
        m_code  = m_stable[5:0];
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && code_ready) begin
      m_valid = 1'b0;
    end

    // The debouncer at this edge sees raw values sampled two edges earlier.
    n       = hist.size();
    nstable = m_stable;
    for (int b = 0; b < 8; b++) begin
      all_diff = 1'b1;
      for (int j = n - 1 - D; j <= n - 2; j++) begin
        if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
      end
      if (all_diff) nstable[b] = ~m_stable[b];
    end
    m_prev_sub = m_stable[6];
    m_stable   = nstable;
    hist.push_back(raw_now);
    while (hist.size() > D + 2) void'(hist.pop_front());
  endtask

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model", 16'({code_valid, overrun, en_level, code}),
                   16'({m_valid, m_ovr, m_stable[7], m_code}));
  endtask

  task automatic wait_en(logic want, string tag);
    int k;
    k = 0;
    while (en_level !== want && k < 30) begin
      tick();
      k++;
    end
    check(tag, 16'(en_level), 16'(want));
  endtask

  // Pulse reset between edges and confirm outputs clear without a clock.
  task automatic async_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    check(tag, 16'({code_valid, overrun, en_level, code}), 16'h0000);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    sw_code    = '0;
    sw_submit  = 1'b0;
    sw_en      = 1'b0;
    code_ready = 1'b0;
    model_reset();

    #12;
    check("reset_state", 16'({code_valid, overrun, en_level, code}), 16'h0000);
    rst_n = 1'b1;

    // Enable the lock and let it debounce.
    sw_en = 1'b1;
    wait_en(1'b1, "enable_up");

    // Basic transfer: valid exactly D+3 edges after the submit rise.
    sw_code = 6'b101001;
    repeat (8) tick();
    sw_submit = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) check("xfer_early", 16'(code_valid), 16'(0));
    end
    check("xfer_valid_e7", 16'(code_valid), 16'(1));
    check("xfer_code", 16'(code), 16'(6'b101001));
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    check("xfer_consumed", 16'(code_valid), 16'(0));

    // Glitch rejection: a 3-cycle press is never accepted.
    sw_submit = 1'b0;
    repeat (8) tick();
    sw_submit = 1'b1;
    repeat (3) tick();
    sw_submit = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check("glitch_no_valid", 16'(code_valid), 16'(0));
    end

    // Overrun: second press while first attempt pends.
    sw_submit = 1'b1;
    repeat (8) tick();
    check("ovr_first_valid", 16'(code_valid), 16'(1));
    sw_submit = 1'b0;
    repeat (8) tick();
    sw_code = 6'b000111;
    repeat (8) tick();
    sw_submit = 1'b1;
    repeat (8) tick();
    check("ovr_flag", 16'(overrun), 16'(1));
    check("ovr_code_kept", 16'(code), 16'(6'b101001));
    check("ovr_still_valid", 16'(code_valid), 16'(1));

    // Abort: disabling drops the attempt and the flag one edge later.
    sw_en = 1'b0;
    wait_en(1'b0, "abort_en_down");
    check("abort_valid_before", 16'(code_valid), 16'(1));
    tick();
    check("abort_valid", 16'(code_valid), 16'(0));
    check("abort_ovr", 16'(overrun), 16'(0));

    // Submit toggling while disabled never produces an attempt.
    for (int t = 0; t < 6; t++) begin
      sw_submit = ~sw_submit;
      repeat (7) tick();
      check("disabled_no_valid", 16'(code_valid), 16'(0));
    end

    // Mid-operation reset while holding an attempt.
    sw_submit = 1'b0;
    sw_en     = 1'b1;
    wait_en(1'b1, "reenable");
    sw_code = 6'b110010;
    repeat (8) tick();
    sw_submit = 1'b1;
    repeat (8) tick();
    check("hold_before_rst", 16'({code_valid, code}), 16'({1'b1, 6'b110010}));
    async_reset("rst_mid_hold");

    // After reset, everything re-debounces from zero.
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("post_rst_en", 16'(en_level), 16'(e >= 6));
      check("post_rst_valid", 16'(code_valid), 16'(e >= 7));
    end
    check("post_rst_code", 16'(code), 16'(6'b110010));

    // Random phase.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) sw_en = ~sw_en;
      if ($urandom_range(0, 5) == 0) sw_submit = ~sw_submit;
      if ($urandom_range(0, 4) == 0) sw_code = 6'($urandom);
      code_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) async_reset("rst_random");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/combo_input_sync.md
COMBO_INPUT_SYNC -- requirements
Module: combo_input_sync

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL default to 50000 and set the consecutive stable cycles required before a switch change is accepted (1 ms at 50 MHz).
REQ-003 Port clk SHALL be input, 1 bit: system clock, rising edge active.
REQ-004 Port rst_n SHALL be input, 1 bit: asynchronous active-low reset.
REQ-005 Port sw_code SHALL be input, 6 bits: raw asynchronous code switches.
REQ-006 Port sw_submit SHALL be input, 1 bit: raw asynchronous submit switch.
REQ-007 Port sw_en SHALL be input, 1 bit: raw asynchronous lock-enable switch.
REQ-008 Port code_ready SHALL be input, 1 bit: the downstream lock FSM accepts the code.
REQ-009 Port code SHALL be output, 6 bits: the captured code attempt.
REQ-010 Port code_valid SHALL be output, 1 bit: code holds an unconsumed attempt.
REQ-011 Port en_level SHALL be output, 1 bit: debounced enable level.
REQ-012 Port overrun SHALL be output, 1 bit: sticky flag indicating a submit was dropped.

Function
REQ-013 Each of the 8 raw inputs SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-014 Each synchronized input SHALL have its own debouncer: a stable value and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-015 The counter SHALL clear in every cycle in which the synchronized input equals the stable value, and SHALL otherwise increment.
REQ-016 When the counter reaches DEBOUNCE_CYCLES, the stable value SHALL take the synchronized value and the counter SHALL clear; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change the stable value.
REQ-017 en_level SHALL equal the debounced sw_en stable value.
REQ-018 A submit event SHALL be a 0->1 transition of the debounced submit, detected against a registered copy and valid only while en_level=1; a 1->0 transition SHALL be ignored.
REQ-019 The handshake control SHALL be an FSM with two states, IDLE (code_valid=0) and HOLD (code_valid=1).
REQ-020 IDLE -> HOLD: on a submit event, the debounced sw_code SHALL be latched into code on the same edge that asserts code_valid.
REQ-021 HOLD -> IDLE: on a clock edge sampling code_ready=1, or on a clock edge sampling en_level=0 (abort, the code is discarded).
REQ-022 While the FSM is in HOLD, code SHALL remain constant.
REQ-023 A submit event while in HOLD and code_ready=0 SHALL be dropped, SHALL set overrun, and SHALL leave code unchanged.
REQ-024 A submit event in HOLD coinciding with code_ready=1 SHALL latch the new code and keep the FSM in HOLD, with no overrun.
REQ-025 overrun SHALL remain set until en_level is sampled 0, and clearing SHALL take priority over setting.
REQ-026 For a clean sw_submit rise held high with en_level=1 and the FSM in IDLE, code_valid SHALL rise exactly DEBOUNCE_CYCLES+3 rising clk edges after the first edge that samples the new level.
REQ-027 code_ready sampled while the FSM is in IDLE SHALL have no effect.

Reset
REQ-028 Asserting rst_n low SHALL immediately, without waiting for a clock edge, clear all synchronizer flops, stable values, counters, edge registers, and outputs: code=0, code_valid=0, en_level=0, overrun=0, FSM=IDLE.
REQ-029 Deasserting rst_n SHALL be treated as synchronous to clk, and the first submit event SHALL require a full debounce from the zero stable values.
REQ-030 rst_n asserted while the FSM is in HOLD SHALL discard the pending code without a transfer.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 The bench SHALL cover a basic transfer: en=1 and debounced; sw_code=6'b101001; sw_submit rises -> code_valid=1 at edge 7 with code=6'b101001; code_ready=1 for one cycle -> code_valid=0 on the next edge.
REQ-032 The bench SHALL cover glitch rejection: sw_submit high for 3 cycles then low -> code_valid stays 0 and the debounced submit never changes.
REQ-033 The bench SHALL cover overrun: one attempt pending with code_ready=0; submit is released and re-pressed with sw_code=6'b000111 -> overrun=1 and code stays 6'b101001.
REQ-034 The bench SHALL cover abort: an attempt pending; sw_en falls and is debounced -> code_valid=0 and overrun=0 on the edge after en_level=0.
REQ-035 The bench SHALL cover submit while disabled: en=0 and sw_submit toggles -> code_valid stays 0.
REQ-036 The bench SHALL cover mid-operation reset: rst_n pulsed low between clock edges while in HOLD -> all outputs are 0 immediately.
